// File: rtl/spi_pkg.sv
// spi_pkg
// Shared types and constants for the configurable SPI slave.
//   state_t             : FSM states (IDLE, ACTIVE)
//   mode_t              : registered transfer mode {cpol, cpha, lsb_first}
//   DEFAULT_SYNC_STAGES : default synchroniser depth for the SPI pins
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } mode_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// spi_sync
// Brings one asynchronous pin into the system clock domain through STAGES
// flops. One extra flop behind the synchronised level gives a single-cycle
// rise/fall indication.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   pin        : asynchronous input
//   level      : synchronised level
//   rise, fall : one-cycle pulses on a synchronised 0->1 / 1->0 change
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg
// SPI slave with runtime CPOL/CPHA and bit order, multi-word bursts inside
// one chip select, a valid/ready TX word handshake, an RX word strobe, an
// underrun strobe and a MISO output enable. SCK is oversampled by i_clk.
// Optional feature macro: SPI_SLAVE_CFG_TXBUF_EN adds a one-word TX holding
// register; without it the TX word is taken straight from i_tx_data.
// Ports:
//   i_clk, i_rst_n                  : system clock, async active-low reset
//   i_cpol, i_cpha, i_lsb_first     : mode, captured only while idle
//   i_sck, i_sce, i_sin             : SPI pins (SCE active low)
//   o_sout, o_soe                   : MISO data and its output enable
//   i_tx_data, i_tx_valid, o_tx_ready : TX word handshake
//   o_rx_data, o_rx_valid           : last complete RX word and its strobe
//   o_tx_underrun                   : strobe when a word was loaded with no data
//   o_busy                          : selected (FSM in ACTIVE)
module spi_slave_cfg
    import spi_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int WORD_BITS   = $clog2(WORD_SIZE),
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cpol,
    input  logic                 i_cpha,
    input  logic                 i_lsb_first,
    input  logic                 i_sck,
    input  logic                 i_sce,
    input  logic                 i_sin,
    output logic                 o_sout,
    output logic                 o_soe,
    input  logic [WORD_SIZE-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [WORD_SIZE-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_tx_underrun,
    output logic                 o_busy
);

    localparam logic [WORD_BITS-1:0] LAST_BIT = WORD_BITS'(WORD_SIZE - 1);

    state_t                 state;
    mode_t                  mode;
    logic [WORD_BITS-1:0]   cnt;
    logic [WORD_SIZE-1:0]   rx_shift;
    logic [WORD_SIZE-1:0]   tx_shift;
    logic                   reload;

    logic sck_level, sck_rise, sck_fall;
    logic sce_level, sce_rise, sce_fall;
    logic sin_level, sin_rise_unused, sin_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES)) sync_sck (
        .clk(i_clk), .rst_n(i_rst_n), .pin(i_sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) sync_sce (
        .clk(i_clk), .rst_n(i_rst_n), .pin(i_sce),
        .level(sce_level), .rise(sce_rise), .fall(sce_fall)
    );

    // SIN goes through the same depth as SCK so its level lines up with
    // the cycle in which the SCK edge is seen.
    spi_sync #(.STAGES(SYNC_STAGES)) sync_sin (
        .clk(i_clk), .rst_n(i_rst_n), .pin(i_sin),
        .level(sin_level), .rise(sin_rise_unused), .fall(sin_fall_unused)
    );

    logic leading, trailing, sample_edge, shift_edge, active_edges;
    logic load, word_avail;
    logic [WORD_SIZE-1:0] word, next_word, rx_next;

    // Leading edge is SCK leaving its idle level; CPHA picks which of the
    // two edges samples. Edges only count while selected and not leaving.
    assign leading      = mode.cpol ? sck_fall : sck_rise;
    assign trailing     = mode.cpol ? sck_rise : sck_fall;
    assign active_edges = (state == ACTIVE) && !sce_rise;
    assign sample_edge  = active_edges && (mode.cpha ? trailing : leading);
    assign shift_edge   = active_edges && (mode.cpha ? leading : trailing);

    // A TX word is loaded either at selection (CPHA=0) or at the first
    // shift edge after a word boundary.
    assign load = ((state == IDLE) && sce_fall && !mode.cpha) ||
                  (shift_edge && reload);

    assign next_word = word_avail ? word : '0;
    assign rx_next   = mode.lsb_first ? {sin_level, rx_shift[WORD_SIZE-1:1]}
                                      : {rx_shift[WORD_SIZE-2:0], sin_level};
    assign o_sout    = mode.lsb_first ? tx_shift[0] : tx_shift[WORD_SIZE-1];

`ifdef SPI_SLAVE_CFG_TXBUF_EN
    logic [WORD_SIZE-1:0] hold_data;
    logic                 hold_full;

    assign o_tx_ready = ~hold_full;
    assign word_avail = hold_full;
    assign word       = hold_data;

    // A load empties the holding register; a write only lands while it
    // is empty, so a same-cycle load and write underruns and then fills.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            if (load) begin
                hold_full <= 1'b0;
            end
            if (i_tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= i_tx_data;
            end
        end
    end
`else
    // Without a holding register the word is taken live in the load cycle.
    assign o_tx_ready = load;
    assign word_avail = i_tx_valid;
    assign word       = i_tx_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            mode          <= '0;
            cnt           <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            reload        <= 1'b0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;
            o_busy        <= 1'b0;
            o_soe         <= 1'b0;
        end else begin
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= load && !word_avail;
            case (state)
                IDLE: begin
                    mode <= '{cpol: i_cpol, cpha: i_cpha, lsb_first: i_lsb_first};
                    if (sce_fall) begin
                        state  <= ACTIVE;
                        o_busy <= 1'b1;
                        o_soe  <= 1'b1;
                        cnt    <= '0;
                        reload <= mode.cpha;
                        if (!mode.cpha) begin
                            tx_shift <= next_word;
                        end
                    end
                end
                ACTIVE: begin
                    if (sce_rise) begin
                        // Deselect throws away any partial RX word and the
                        // pending TX word.
                        state    <= IDLE;
                        o_busy   <= 1'b0;
                        o_soe    <= 1'b0;
                        cnt      <= '0;
                        reload   <= 1'b0;
                        rx_shift <= '0;
                        tx_shift <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            if (cnt == LAST_BIT) begin
                                o_rx_data  <= rx_next;
                                o_rx_valid <= 1'b1;
                                cnt        <= '0;
                                reload     <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (reload) begin
                                tx_shift <= next_word;
                                reload   <= 1'b0;
                            end else if (mode.lsb_first) begin
                                tx_shift <= tx_shift >> 1;
                            end else begin
                                tx_shift <= tx_shift << 1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_cfg.sv
// tb_spi_slave_cfg
// Drives spi_slave_cfg (WORD_SIZE=8) as an SPI master. A reference model of
// the TX word stream and the words sent by the master fill expectation
// queues; an RX monitor checks every o_rx_valid strobe against them, and the
// master checks each MISO word it clocks in.
module tb_spi_slave_cfg;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int H  = 8;   // SCK half period in i_clk cycles

`ifdef SPI_SLAVE_CFG_TXBUF_EN
    localparam logic READY_RST = 1'b1;
`else
    localparam logic READY_RST = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_cpol = 1'b0, i_cpha = 1'b0, i_lsb_first = 1'b0;
    logic         i_sck = 1'b0, i_sce = 1'b1, i_sin = 1'b0;
    logic [W-1:0] i_tx_data = '0;
    logic         i_tx_valid = 1'b0;
    logic         o_sout, o_soe, o_tx_ready, o_rx_valid, o_tx_underrun, o_busy;
    logic [W-1:0] o_rx_data;

    int checks = 0;
    int fails  = 0;
    int underrun_seen = 0;
    int underrun_exp  = 0;

    logic [W-1:0] drv_q[$];       // words the TX driver still offers
    logic [W-1:0] model_q[$];     // reference view of words available to loads
    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] exp_miso_q[$];
    logic [W-1:0] mosi_w[4];
    logic [W-1:0] tx_w[5];
    logic [W-1:0] last_rx = '0;

    spi_slave_cfg #(.WORD_SIZE(W), .SYNC_STAGES(SS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cpol(i_cpol), .i_cpha(i_cpha), .i_lsb_first(i_lsb_first),
        .i_sck(i_sck), .i_sce(i_sce), .i_sin(i_sin),
        .o_sout(o_sout), .o_soe(o_soe),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .o_tx_underrun(o_tx_underrun), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // TX driver: offers the head of drv_q and retires it after a handshake.
    initial begin
        logic take;
        forever begin
            @(negedge i_clk);
            take = o_tx_ready && i_tx_valid && i_rst_n;
            @(posedge i_clk);
            #1;
            if (take && drv_q.size() > 0) void'(drv_q.pop_front());
            i_tx_valid = (drv_q.size() > 0);
            i_tx_data  = (drv_q.size() > 0) ? drv_q[0] : '0;
        end
    end

    // RX monitor and underrun counter.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge i_clk);
            if (o_tx_underrun) underrun_seen++;
            if (o_rx_valid) begin
                if (exp_rx_q.size() == 0) begin
                    check_output("rx unexpected strobe", 1, 0);
                end else begin
                    e = exp_rx_q.pop_front();
                    check_output("rx word", o_rx_data, e);
                end
            end
        end
    end

    // One chip-select transfer. abort_bits > 0 deselects after that many
    // bits of the first word. Every load takes the next offered word in
    // order, otherwise zeros go out and an underrun is expected. CPHA=0
    // loads at selection and after every word (the last one is dropped);
    // CPHA=1 loads at the start of every word.
    task automatic apply_stimulus(input logic cpol, input logic cpha, input logic lsb,
                                  input int nwords, input int ntx, input int abort_bits);
        int nloads, nbits, wi, bi;
        logic [W-1:0] got, miso;
        logic bitv;
        nloads = (abort_bits > 0) ? 1 : nwords + (cpha ? 0 : 1);
        for (int i = 0; i < ntx; i++) begin
            drv_q.push_back(tx_w[i]);
            model_q.push_back(tx_w[i]);
        end
        for (int i = 0; i < nloads; i++) begin
            if (model_q.size() > 0) got = model_q.pop_front();
            else begin
                got = '0;
                underrun_exp++;
            end
            if (abort_bits == 0 && i < nwords) exp_miso_q.push_back(got);
        end
        if (abort_bits == 0) begin
            for (int i = 0; i < nwords; i++) exp_rx_q.push_back(mosi_w[i]);
            last_rx = mosi_w[nwords-1];
        end

        i_cpol = cpol; i_cpha = cpha; i_lsb_first = lsb; i_sck = cpol; i_sin = 1'b0;
        repeat (2*H) @(negedge i_clk);
        i_sce = 1'b0;
        repeat (H) @(negedge i_clk);
        check_output("busy/soe while selected", {o_busy, o_soe}, 2'b11);
        nbits = (abort_bits > 0) ? abort_bits : nwords * W;
        miso = '0;
        for (int b = 0; b < nbits; b++) begin
            wi = b / W;
            bi = b % W;
            bitv = lsb ? mosi_w[wi][bi] : mosi_w[wi][W-1-bi];
            if (!cpha) begin
                i_sin = bitv;
                repeat (H) @(negedge i_clk);
                miso[lsb ? bi : W-1-bi] = o_sout;
                i_sck = ~cpol;
                repeat (H) @(negedge i_clk);
                i_sck = cpol;
            end else begin
                i_sck = ~cpol;
                i_sin = bitv;
                repeat (H) @(negedge i_clk);
                miso[lsb ? bi : W-1-bi] = o_sout;
                i_sck = cpol;
                repeat (H) @(negedge i_clk);
            end
            // Mode pins are scrambled mid-transfer; they must be ignored.
            if (b == 1) begin
                i_cpol = 1'($urandom_range(0, 1));
                i_cpha = 1'($urandom_range(0, 1));
                i_lsb_first = 1'($urandom_range(0, 1));
            end
            if (abort_bits == 0 && bi == W-1) begin
                if (exp_miso_q.size() == 0) check_output("miso missing expectation", 1, 0);
                else check_output("miso word", miso, exp_miso_q.pop_front());
            end
        end
        repeat (H) @(negedge i_clk);
        i_sce = 1'b1;
        repeat (2*H) @(negedge i_clk);
        check_output("rx strobes outstanding", exp_rx_q.size(), 0);
        check_output("underrun count", underrun_seen, underrun_exp);
        check_output("busy/soe after deselect", {o_busy, o_soe}, 2'b00);
        if (abort_bits > 0) check_output("rx_data held after abort", o_rx_data, last_rx);
    endtask

    initial begin
        int nw, nl, ntx;
        logic cp, ph, ls;

        // Reset values.
        repeat (3) @(negedge i_clk);
        check_output("reset outputs", {o_sout, o_soe, o_rx_valid, o_tx_underrun, o_busy, o_tx_ready},
                     {5'b0, READY_RST});
        check_output("reset rx_data", o_rx_data, 0);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);

        // Mode 0, MSB first: 0xA5 in, 0x3C out.
        mosi_w[0] = 8'hA5; tx_w[0] = 8'h3C; tx_w[1] = 8'h3C;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1, 2, 0);

        // All four modes, LSB first, 0x81 both ways.
        for (int m = 0; m < 4; m++) begin
            mosi_w[0] = 8'h81; tx_w[0] = 8'h81; tx_w[1] = 8'h81;
            apply_stimulus(1'(m >> 1), 1'(m & 1), 1'b1, 1, (m & 1) ? 1 : 2, 0);
        end

        // Three-word burst, every load supplied.
        mosi_w[0] = 8'h5A; mosi_w[1] = 8'hC3; mosi_w[2] = 8'h0F;
        tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
        apply_stimulus(1'b0, 1'b1, 1'b0, 3, 3, 0);

        // Two-word burst, one TX word: second word is zeros, one underrun.
        mosi_w[0] = 8'h96; mosi_w[1] = 8'h69; tx_w[0] = 8'hE7;
        apply_stimulus(1'b1, 1'b1, 1'b0, 2, 1, 0);

        // Deselect after 5 bits, then a clean transfer.
        mosi_w[0] = 8'hFF; tx_w[0] = 8'h44;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1, 1, 5);
        mosi_w[0] = 8'h3B; tx_w[0] = 8'hB3; tx_w[1] = 8'h00;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1, 2, 0);

        // Reset in the middle of a word.
        i_cpol = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0; i_sck = 1'b0;
        drv_q.push_back(8'hFF);
        repeat (2*H) @(negedge i_clk);
        i_sce = 1'b0;
        repeat (H) @(negedge i_clk);
        i_sin = 1'b1; i_sck = 1'b1;
        repeat (H) @(negedge i_clk);
        i_sck = 1'b0;
        repeat (H) @(negedge i_clk);
        check_output("selected before reset", {o_busy, o_sout}, 2'b11);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_output("async reset outputs", {o_sout, o_soe, o_rx_valid, o_tx_underrun, o_busy, o_tx_ready},
                     {5'b0, READY_RST});
        check_output("async reset rx_data", o_rx_data, 0);
        drv_q.delete(); model_q.delete(); exp_rx_q.delete(); exp_miso_q.delete();
        i_sce = 1'b1; i_sck = 1'b0; i_sin = 1'b0;
        repeat (4) @(negedge i_clk);
        underrun_seen = 0; underrun_exp = 0; last_rx = '0;
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        mosi_w[0] = 8'hD2; tx_w[0] = 8'h2D; tx_w[1] = 8'h7E;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1, 2, 0);

        // Randomised transfers.
        for (int t = 0; t < 12; t++) begin
            cp = 1'($urandom_range(0, 1));
            ph = 1'($urandom_range(0, 1));
            ls = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) mosi_w[i] = W'($urandom);
            for (int i = 0; i < 5; i++) tx_w[i] = W'($urandom);
            nl = nw + (ph ? 0 : 1);
            ntx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl) : nl;
            apply_stimulus(cp, ph, ls, nw, ntx, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
